// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Two-requester round-robin arbiter in front of a single in-order
//            memory port with fixed read latency. Accepted requests are
//            registered onto the memory port for one cycle. Read requester
//            tags travel through a MEM_LATENCY-deep pipeline, so each response
//            is steered back to the requester that issued it.
// Ports    : clk, rst              - clock, async active-high reset
//            rq<i>_valid/ready     - request handshake (i = 0, 1)
//            rq<i>_addr/we/wdata   - request word address, write flag, data
//            rs<i>_valid/data      - read response to requester i
//            mem_req_addr/data     - registered memory address / write data
//            mem_read_en/write_en  - one-cycle memory strobes
//            mem_resp_data         - memory read data, MEM_LATENCY after read
//            idle                  - no strobe, nothing in flight, no request
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int BANKING_FACTOR = 1,
  parameter int ADDRESS_WIDTH  = 13,
  parameter int MEM_LATENCY    = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,

  input  logic                                 rq0_valid,
  output logic                                 rq0_ready,
  input  logic [ADDRESS_WIDTH-1:0]             rq0_addr,
  input  logic                                 rq0_we,
  input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] rq0_wdata,
  output logic                                 rs0_valid,
  output logic [BANKING_FACTOR*DATA_WIDTH-1:0] rs0_data,

  input  logic                                 rq1_valid,
  output logic                                 rq1_ready,
  input  logic [ADDRESS_WIDTH-1:0]             rq1_addr,
  input  logic                                 rq1_we,
  input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] rq1_wdata,
  output logic                                 rs1_valid,
  output logic [BANKING_FACTOR*DATA_WIDTH-1:0] rs1_data,

  output logic [ADDRESS_WIDTH-1:0]             mem_req_addr,
  output logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_req_data,
  output logic                                 mem_read_en,
  output logic                                 mem_write_en,
  input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_resp_data,

  output logic                                 idle
);

  localparam int c_bus_w = BANKING_FACTOR * DATA_WIDTH;

  // Priority pointer: names the requester that wins when both are valid.
  logic                     r_ptr;
  logic                     r_rd_en;
  logic                     r_wr_en;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [c_bus_w-1:0]       r_data;
  logic                     r_issue_tag;   // requester owning the read on the port
  logic [MEM_LATENCY-1:0]   r_pipe_v;
  logic [MEM_LATENCY-1:0]   r_pipe_tag;

  logic                     w_both;
  logic                     w_grant0;
  logic                     w_grant1;
  logic                     w_accept;
  logic                     w_sel_we;
  logic [ADDRESS_WIDTH-1:0] w_sel_addr;
  logic [c_bus_w-1:0]       w_sel_wdata;

  // Grants are gated by rst so no request is acknowledged while the
  // registers are being held in reset.
  assign w_both   = rq0_valid & rq1_valid;
  assign w_grant0 = ~rst & rq0_valid & (~rq1_valid | ~r_ptr);
  assign w_grant1 = ~rst & rq1_valid & (~rq0_valid |  r_ptr);
  assign w_accept = w_grant0 | w_grant1;

  assign w_sel_we    = w_grant1 ? rq1_we    : rq0_we;
  assign w_sel_addr  = w_grant1 ? rq1_addr  : rq0_addr;
  assign w_sel_wdata = w_grant1 ? rq1_wdata : rq0_wdata;

  assign rq0_ready = w_grant0;
  assign rq1_ready = w_grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_issue_tag <= 1'b0;
      r_pipe_v    <= '0;
      r_pipe_tag  <= '0;
    end else begin
      r_rd_en <= w_accept & ~w_sel_we;
      r_wr_en <= w_accept &  w_sel_we;

      // Address/data hold their last values between issues.
      if (w_accept) begin
        r_addr      <= w_sel_addr;
        r_data      <= w_sel_wdata;
        r_issue_tag <= w_grant1;
      end

      // Only a contended acceptance rotates priority; a sole requester
      // can stream without disturbing fairness for the next contention.
      if (w_accept && w_both) begin
        r_ptr <= ~r_ptr;
      end

      // Stage 0 is loaded from the read strobe cycle, so the last stage is
      // valid exactly MEM_LATENCY cycles after mem_read_en.
      r_pipe_v[0]   <= r_rd_en;
      r_pipe_tag[0] <= r_issue_tag;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        r_pipe_v[k]   <= r_pipe_v[k-1];
        r_pipe_tag[k] <= r_pipe_tag[k-1];
      end
    end
  end

  assign mem_req_addr = r_addr;
  assign mem_req_data = r_data;
  assign mem_read_en  = r_rd_en;
  assign mem_write_en = r_wr_en;

  assign rs0_valid = r_pipe_v[MEM_LATENCY-1] & ~r_pipe_tag[MEM_LATENCY-1];
  assign rs1_valid = r_pipe_v[MEM_LATENCY-1] &  r_pipe_tag[MEM_LATENCY-1];
  assign rs0_data  = mem_resp_data;
  assign rs1_data  = mem_resp_data;

  // A response cycle still counts as in flight, so idle rises the cycle
  // after the last rs_valid.
  assign idle = rst | (~r_rd_en & ~r_wr_en & ~(|r_pipe_v) & ~rq0_valid & ~rq1_valid);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. A mock memory holding
//            addr+0x1000 answers reads one cycle after mem_read_en. A
//            transaction-level reference model (round-robin rule, expected
//            strobes, queue of expected responses) is compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int DW = 16;
  localparam int BF = 1;
  localparam int AW = 13;
  localparam int L  = 1;
  localparam int W  = DW * BF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rq0_valid = 1'b0, rq1_valid = 1'b0;
  logic          rq0_ready, rq1_ready;
  logic [AW-1:0] rq0_addr = '0, rq1_addr = '0;
  logic          rq0_we = 1'b0, rq1_we = 1'b0;
  logic [W-1:0]  rq0_wdata = '0, rq1_wdata = '0;
  logic          rs0_valid, rs1_valid;
  logic [W-1:0]  rs0_data, rs1_data;
  logic [AW-1:0] mem_req_addr;
  logic [W-1:0]  mem_req_data;
  logic          mem_read_en, mem_write_en;
  logic [W-1:0]  mem_resp_data;
  logic          idle;

  mem_port_arbiter #(
    .DATA_WIDTH(DW), .BANKING_FACTOR(BF), .ADDRESS_WIDTH(AW), .MEM_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_addr(rq0_addr),
    .rq0_we(rq0_we), .rq0_wdata(rq0_wdata), .rs0_valid(rs0_valid), .rs0_data(rs0_data),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_addr(rq1_addr),
    .rq1_we(rq1_we), .rq1_wdata(rq1_wdata), .rs1_valid(rs1_valid), .rs1_data(rs1_data),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_resp_data(mem_resp_data), .idle(idle)
  );

  always #5 clk = ~clk;

  // Mock memory (environment, not the reference model).
  logic [W-1:0] mock [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_write_en) mock[mem_req_addr] <= mem_req_data;
    if (mem_read_en)  mem_resp_data <= mock[mem_req_addr];
  end

  // Reference model state.
  typedef struct { int due; bit tag; logic [W-1:0] data; } rsp_t;
  rsp_t         q[$];
  logic [W-1:0] ref_mem [0:(1<<AW)-1];
  bit           m_ptr;
  bit           m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_data;
  int           cyc;
  int           n_checks, n_pass, n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Check the current cycle at the falling edge, advance the model, then
  // move to just after the next rising edge where new inputs are applied.
  task automatic step();
    bit g0, g1, e_rs0, e_rs1, busy;
    logic [W-1:0] e_data;
    @(negedge clk);
    if (rst) begin
      check("rst_ready0", rq0_ready, 0);
      check("rst_ready1", rq1_ready, 0);
      check("rst_rd_en", mem_read_en, 0);
      check("rst_wr_en", mem_write_en, 0);
      check("rst_rs0", rs0_valid, 0);
      check("rst_rs1", rs1_valid, 0);
      check("rst_idle", idle, 1);
      check("rst_addr", mem_req_addr, 0);
      check("rst_data", mem_req_data, 0);
      m_ptr = 0; m_rd = 0; m_wr = 0; m_addr = '0; m_data = '0;
      q.delete();
    end else begin
      if (m_wr) ref_mem[m_addr] = m_data;
      g0 = rq0_valid && (!rq1_valid || !m_ptr);
      g1 = rq1_valid && (!rq0_valid ||  m_ptr);
      check("ready0", rq0_ready, g0);
      check("ready1", rq1_ready, g1);
      check("mem_read_en", mem_read_en, m_rd);
      check("mem_write_en", mem_write_en, m_wr);
      check("mem_req_addr", mem_req_addr, m_addr);
      check("mem_req_data", mem_req_data, m_data);
      busy   = (q.size() != 0);
      e_rs0  = busy && q[0].due == cyc && !q[0].tag;
      e_rs1  = busy && q[0].due == cyc &&  q[0].tag;
      e_data = busy ? q[0].data : '0;
      check("rs0_valid", rs0_valid, e_rs0);
      check("rs1_valid", rs1_valid, e_rs1);
      if (e_rs0) check("rs0_data", rs0_data, e_data);
      if (e_rs1) check("rs1_data", rs1_data, e_data);
      if (e_rs0 || e_rs1) void'(q.pop_front());
      check("idle", idle, !m_rd && !m_wr && !busy && !rq0_valid && !rq1_valid);
      m_rd = 0; m_wr = 0;
      if (g0 || g1) begin
        m_wr   = g1 ? rq1_we : rq0_we;
        m_rd   = !m_wr;
        m_addr = g1 ? rq1_addr : rq0_addr;
        m_data = g1 ? rq1_wdata : rq0_wdata;
        if (m_rd) q.push_back('{due: cyc + 1 + L, tag: g1, data: ref_mem[m_addr]});
        if (rq0_valid && rq1_valid) m_ptr = !m_ptr;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rq(input int i, input bit v, input int addr, input bit we, input int wd);
    if (i == 0) begin
      rq0_valid = v; rq0_addr = AW'(addr); rq0_we = we; rq0_wdata = W'(wd);
    end else begin
      rq1_valid = v; rq1_addr = AW'(addr); rq1_we = we; rq1_wdata = W'(wd);
    end
  endtask

  task automatic clear_and_wait(input int n);
    set_rq(0, 0, 0, 0, 0);
    set_rq(1, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      mock[a]    = W'(a + 'h1000);
      ref_mem[a] = W'(a + 'h1000);
    end
    cyc = 0; n_checks = 0; n_pass = 0; n_fail = 0;
    m_ptr = 0; m_rd = 0; m_wr = 0; m_addr = '0; m_data = '0;
    mem_resp_data = '0;

    // Reset state
    @(posedge clk); #1;
    step();
    step();
    rst = 1'b0;

    // Single read from rq0 accepted on the first edge after reset
    set_rq(0, 1, 'h100, 0, 0);
    step();
    clear_and_wait(4);

    // Contention: grants alternate 0,1,0,1
    set_rq(0, 1, 'h000, 0, 0);
    set_rq(1, 1, 'h010, 0, 0);
    repeat (4) step();
    clear_and_wait(4);

    // Sole requester streams three reads with no bubbles
    for (int k = 0; k < 3; k++) begin
      set_rq(1, 1, 'h20 + k, 0, 0);
      step();
    end
    clear_and_wait(3);
    // Pointer unchanged: contention still goes to rq0 (pointer then moves to 1)
    set_rq(0, 1, 'h030, 0, 0);
    set_rq(1, 1, 'h031, 0, 0);
    step();
    clear_and_wait(3);

    // Write then read of the same address
    set_rq(0, 1, 'h010, 1, 'hBEEF);
    step();
    set_rq(0, 1, 'h010, 0, 0);
    step();
    clear_and_wait(4);

    // Reset mid-flight: pointer is 1 here, read dropped, pointer back to 0
    set_rq(0, 1, 'h200, 0, 0);
    step();
    set_rq(0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    set_rq(0, 1, 'h040, 0, 0);
    set_rq(1, 1, 'h041, 0, 0);
    step();
    clear_and_wait(4);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      set_rq(0, 1'($urandom_range(0, 1)), $urandom_range(0, 31), 1'($urandom_range(0, 3) == 0), $urandom);
      set_rq(1, 1'($urandom_range(0, 1)), $urandom_range(0, 31), 1'($urandom_range(0, 3) == 0), $urandom);
      step();
    end

    // Drain; idle must rise the cycle after the last response
    clear_and_wait(6);
    check("drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
